tlb_lookup_unit: RTL and testbench

- Main joint TLB array: the responder behind the per-stage translation buffers.
- Answers search requests from the instruction buffer (port s0) and the data buffer/TLBP (port s1), each with a registered one-cycle response.
- Executes TLBWI/TLBWR writes and TLBR reads from the CP0 side, and maintains the Random counter.
- Issues a flush pulse so the translation buffers drop stale copies after any array write.

---
 rtl/tlb_lookup_unit_pkg.sv | 29 ++
 rtl/tlb_lookup_unit_match_cam.sv | 39 +++
 rtl/tlb_lookup_unit.sv | 126 ++++++++++++
 tb/tb_tlb_lookup_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_lookup_unit_pkg.sv
// Shared TLB types and constants used by the joint TLB array and the
// per-stage translation buffers.
package tlb_lookup_unit_pkg;

    localparam int TLBNUM_DEF = 16;
    localparam int IDXW_DEF   = $clog2(TLBNUM_DEF);

    localparam logic [2:0] CACHE_ATTR_CACHED = 3'b011;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } TLB_Entry;

    // Valid bits deliberately ignored; the buffers raise Invalid from V0/V1.
    function automatic logic entry_match(TLB_Entry e, logic [18:0] vpn2, logic [7:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

endpackage

// File: rtl/tlb_lookup_unit_match_cam.sv
// Combinational CAM search: parallel compare across all entries, lowest
// matching index wins.
module tlb_lookup_unit_match_cam
    import tlb_lookup_unit_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  TLB_Entry          entries [TLBNUM],
    input  logic [18:0]       vpn2,
    input  logic [7:0]        asid,
    output logic              hit,
    output logic [IDXW-1:0]   hit_index,
    output TLB_Entry          hit_entry
);

    logic [TLBNUM-1:0] match;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            match[i] = entry_match(entries[i], vpn2, asid);
        end
    end

    // Scan from the top so the lowest matching index is the last to assign.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        hit_entry = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                hit_index = IDXW'(i);
                hit_entry = entries[i];
            end
        end
    end

endmodule

// File: rtl/tlb_lookup_unit.sv
// Joint TLB array: two registered search ports, TLBWI/TLBWR/TLBR access,
// Random counter and a flush pulse to the translation buffers after writes.
module tlb_lookup_unit
    import tlb_lookup_unit_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       cp0_asid,
    input  logic [18:0]      s0_vpn2,
    output TLB_Entry         s0_entry,
    output logic             s0_found,
    output logic [IDXW-1:0]  s0_index,
    input  logic [18:0]      s1_vpn2,
    output TLB_Entry         s1_entry,
    output logic             s1_found,
    output logic [IDXW-1:0]  s1_index,
    input  logic             we,
    input  logic             w_random,
    input  logic [IDXW-1:0]  w_index,
    input  TLB_Entry         w_entry,
    input  logic [IDXW-1:0]  r_index,
    output TLB_Entry         r_entry,
    input  logic [IDXW-1:0]  cp0_wired,
    output logic [IDXW-1:0]  random_out,
    output logic             tlb_flush
);

    localparam logic [IDXW-1:0] RandTop = IDXW'(TLBNUM - 1);

    TLB_Entry        entry_q [TLBNUM];
    logic [IDXW-1:0] w_target;

    logic            s0_hit,   s1_hit;
    logic [IDXW-1:0] s0_hit_index, s1_hit_index;
    TLB_Entry        s0_hit_entry, s1_hit_entry;

    logic [IDXW-1:0] random_q, random_d;
    logic [IDXW-1:0] wired_q;
    logic            flush_q;

    // TLBWR targets the Random value visible before this edge's decrement.
    assign w_target = w_random ? random_q : w_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
        end else if (we) begin
            entry_q[w_target] <= w_entry;
        end
    end

    tlb_lookup_unit_match_cam #(
        .TLBNUM (TLBNUM),
        .IDXW   (IDXW)
    ) u_cam_s0 (
        .entries   (entry_q),
        .vpn2      (s0_vpn2),
        .asid      (cp0_asid),
        .hit       (s0_hit),
        .hit_index (s0_hit_index),
        .hit_entry (s0_hit_entry)
    );

    tlb_lookup_unit_match_cam #(
        .TLBNUM (TLBNUM),
        .IDXW   (IDXW)
    ) u_cam_s1 (
        .entries   (entry_q),
        .vpn2      (s1_vpn2),
        .asid      (cp0_asid),
        .hit       (s1_hit),
        .hit_index (s1_hit_index),
        .hit_entry (s1_hit_entry)
    );

    // Search and read registers sample pre-write array contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_found <= 1'b0;
            s0_index <= '0;
            s0_entry <= '0;
            s1_found <= 1'b0;
            s1_index <= '0;
            s1_entry <= '0;
            r_entry  <= '0;
        end else begin
            s0_found <= s0_hit;
            s0_index <= s0_hit_index;
            s0_entry <= s0_hit_entry;
            s1_found <= s1_hit;
            s1_index <= s1_hit_index;
            s1_entry <= s1_hit_entry;
            r_entry  <= entry_q[r_index];
        end
    end

    // A change of Wired, or an out-of-range Wired, pins Random to the top.
    always_comb begin
        random_d = random_q - IDXW'(1);
        if ((cp0_wired != wired_q) || (int'(cp0_wired) > TLBNUM - 1) ||
            (random_q == cp0_wired) || (random_q == '0)) begin
            random_d = RandTop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= RandTop;
            wired_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            random_q <= random_d;
            wired_q  <= cp0_wired;
            flush_q  <= we;
        end
    end

    assign random_out = random_q;
    assign tlb_flush  = flush_q;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Scoreboard bench for tlb_lookup_unit: expectations queued at drive time,
// compared on the falling edge once the registered response is due.
module tb_tlb_lookup_unit;
    import tlb_lookup_unit_pkg::*;

    localparam int N = TLBNUM_DEF;
    localparam int W = IDXW_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cp0_asid;
    logic [18:0]   s0_vpn2, s1_vpn2;
    TLB_Entry      s0_entry, s1_entry, w_entry, r_entry;
    logic          s0_found, s1_found;
    logic [W-1:0]  s0_index, s1_index, w_index, r_index, cp0_wired, random_out;
    logic          we, w_random, tlb_flush;

    always #5 clk = ~clk;

    tlb_lookup_unit #(
        .TLBNUM (N),
        .IDXW   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cp0_asid   (cp0_asid),
        .s0_vpn2    (s0_vpn2),
        .s0_entry   (s0_entry),
        .s0_found   (s0_found),
        .s0_index   (s0_index),
        .s1_vpn2    (s1_vpn2),
        .s1_entry   (s1_entry),
        .s1_found   (s1_found),
        .s1_index   (s1_index),
        .we         (we),
        .w_random   (w_random),
        .w_index    (w_index),
        .w_entry    (w_entry),
        .r_index    (r_index),
        .r_entry    (r_entry),
        .cp0_wired  (cp0_wired),
        .random_out (random_out),
        .tlb_flush  (tlb_flush)
    );

    typedef enum int {
        SelFound0, SelIndex0, SelEntry0, SelFound1, SelIndex1, SelEntry1,
        SelREntry, SelFlush, SelRandom
    } sel_e;

    typedef struct {
        int           due;
        sel_e         sel;
        logic [127:0] val;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] observe(sel_e s);
        case (s)
            SelFound0: return 128'(s0_found);
            SelIndex0: return 128'(s0_index);
            SelEntry0: return 128'(s0_entry);
            SelFound1: return 128'(s1_found);
            SelIndex1: return 128'(s1_index);
            SelEntry1: return 128'(s1_entry);
            SelREntry: return 128'(r_entry);
            SelFlush:  return 128'(tlb_flush);
            SelRandom: return 128'(random_out);
            default:   return '0;
        endcase
    endfunction

    // Expected value for the response produced by the next rising edge.
    task automatic sb_push(sel_e sel, logic [127:0] val, string tag);
        exp_t e;
        e.due = cyc + 1;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check_eq(mon_e.tag, observe(mon_e.sel), mon_e.val);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tlb_write(input logic [W-1:0] idx, input TLB_Entry e);
        we       = 1'b1;
        w_random = 1'b0;
        w_index  = idx;
        w_entry  = e;
    endtask

    function automatic TLB_Entry mk(logic [18:0] vpn2, logic [7:0] asid, logic g,
                                    logic [19:0] pfn0, logic v0, logic [19:0] pfn1);
        TLB_Entry e;
        e      = '0;
        e.vpn2 = vpn2;
        e.asid = asid;
        e.g    = g;
        e.pfn0 = pfn0;
        e.c0   = CACHE_ATTR_CACHED;
        e.v0   = v0;
        e.pfn1 = pfn1;
        e.c1   = CACHE_ATTR_CACHED;
        e.d1   = 1'b1;
        return e;
    endfunction

    TLB_Entry e5, e5g, e7, e9, ex;
    int       exp_r;

    initial begin
        e5  = mk(19'h00400, 8'h12, 1'b0, 20'h01234, 1'b1, 20'h00000);
        e5g = mk(19'h00400, 8'h12, 1'b1, 20'h01234, 1'b1, 20'h05678);
        e7  = mk(19'h12345, 8'h55, 1'b1, 20'h0abcd, 1'b1, 20'h0dcba);
        e9  = mk(19'h7a5a5, 8'h9c, 1'b0, 20'hfeed1, 1'b0, 20'hbeef2);
        ex  = mk(19'h00000, 8'h00, 1'b1, 20'h11111, 1'b1, 20'h22222);

        rst = 1'b1; cp0_asid = '0; s0_vpn2 = '0; s1_vpn2 = '0;
        we = 1'b0; w_random = 1'b0; w_index = '0; w_entry = '0;
        r_index = '0; cp0_wired = '0;

        // Reset state
        step();
        sb_push(SelFound0, 0, "rst_s0_found");
        sb_push(SelIndex0, 0, "rst_s0_index");
        sb_push(SelEntry0, 0, "rst_s0_entry");
        sb_push(SelFound1, 0, "rst_s1_found");
        sb_push(SelREntry, 0, "rst_r_entry");
        sb_push(SelFlush,  0, "rst_flush");
        sb_push(SelRandom, 15, "rst_random");
        step();
        rst = 1'b0;
        s0_vpn2 = 19'h00400;
        sb_push(SelFound0, 0, "empty_miss_found");
        sb_push(SelIndex0, 0, "empty_miss_index");
        sb_push(SelEntry0, 0, "empty_miss_entry");

        // TLBWI idx 5, then ASID-qualified hit and miss
        step();
        tlb_write(5, e5);
        sb_push(SelFlush, 1, "wi5_flush_on");
        step();
        we = 1'b0;
        cp0_asid = 8'h12;
        sb_push(SelFlush,  0, "wi5_flush_off");
        sb_push(SelFound0, 1, "asid12_found");
        sb_push(SelIndex0, 5, "asid12_index");
        sb_push(SelEntry0, 128'(e5), "asid12_entry");
        step();
        cp0_asid = 8'h34;
        sb_push(SelFound0, 0, "asid34_miss");
        sb_push(SelIndex0, 0, "asid34_miss_index");

        // Global entry, then duplicate at lower index
        step();
        tlb_write(5, e5g);
        step();
        we = 1'b0;
        sb_push(SelFound0, 1, "global_found");
        sb_push(SelIndex0, 5, "global_index");
        step();
        tlb_write(3, e5g);
        s1_vpn2 = 19'h00400;
        step();
        we = 1'b0;
        sb_push(SelFound0, 1, "dup_s0_found");
        sb_push(SelIndex0, 3, "dup_s0_index");
        sb_push(SelFound1, 1, "dup_s1_found");
        sb_push(SelIndex1, 3, "dup_s1_index");
        sb_push(SelEntry1, 128'(e5g), "dup_s1_entry");

        // Write and search the same entry in one cycle
        step();
        tlb_write(7, e7);
        s1_vpn2 = 19'h12345;
        sb_push(SelFound1, 0, "wr_search_stale");
        sb_push(SelFlush,  1, "wr_search_flush");
        step();
        we = 1'b0;
        sb_push(SelFound1, 1, "wr_search_found");
        sb_push(SelIndex1, 7, "wr_search_index");
        sb_push(SelEntry1, 128'(e7), "wr_search_entry");
        sb_push(SelFlush,  0, "wr_search_flush_off");

        // Random sequence with Wired = 4, TLBWR when Random reads 9
        step();
        cp0_wired = 4;
        exp_r = 15;
        for (int k = 0; k < 14; k++) begin
            sb_push(SelRandom, 128'(exp_r), "random_seq");
            step();
            we = 1'b0;
            if (exp_r == 9) begin
                we       = 1'b1;
                w_random = 1'b1;
                w_index  = 2;
                w_entry  = e9;
                sb_push(SelFlush, 1, "tlbwr_flush");
            end
            exp_r = (exp_r == 4) ? 15 : exp_r - 1;
        end
        we = 1'b0;
        w_random = 1'b0;
        r_index = 9;
        sb_push(SelREntry, 128'(e9), "tlbr_idx9");
        step();
        r_index = 2;
        sb_push(SelREntry, 0, "tlbr_idx2_untouched");

        // Reset asserted during a write
        step();
        rst = 1'b1;
        tlb_write(2, ex);
        s0_vpn2 = '0;
        s1_vpn2 = '0;
        cp0_asid = '0;
        r_index = 5;
        sb_push(SelFlush,  0, "rstwr_no_flush");
        sb_push(SelFound0, 0, "rstwr_s0_miss");
        sb_push(SelIndex0, 0, "rstwr_s0_index");
        sb_push(SelEntry0, 0, "rstwr_s0_entry");
        sb_push(SelFound1, 0, "rstwr_s1_miss");
        sb_push(SelIndex1, 0, "rstwr_s1_index");
        sb_push(SelREntry, 0, "rstwr_r_entry");
        step();
        rst = 1'b0;
        we = 1'b0;
        sb_push(SelFlush,  0, "postrst_no_flush");
        sb_push(SelREntry, 0, "postrst_idx5_cleared");
        step();
        r_index = 2;
        sb_push(SelREntry, 0, "postrst_idx2_not_written");
        step();
        r_index = 7;
        sb_push(SelREntry, 0, "postrst_idx7_cleared");

        for (int k = 0; k < 4 && sb.size() > 0; k++) step();
        check_eq("scoreboard_drained", 128'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
